mips_regfile_wr: RTL
====================

Name: mips_regfile_wr

Overview:
- MIPS register file, 32 x 32 bits, placed directly downstream of the 5-bit write-register select mux.
- The mux output (rt or rd, chosen by RegDst) drives the write address `wa` of this block.
- Provides two asynchronous read ports for the ID stage and one synchronous write port for the WB stage.
- Tracks per-register "written since reset" status and counts committed writes, for debug and bench checking.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- we  input  1  write enable (RegWrite from WB).
- wa  input  ADDR_W  write address, from the 5-bit write-register mux.
- wd  input  DATA_W  write data.
- ra1  input  ADDR_W  read address port 1 (rs).
- ra2  input  ADDR_W  read address port 2 (rt).
- rd1  output  DATA_W  read data port 1.
- rd2  output  DATA_W  read data port 2.
- rd1_valid  output  1  register at ra1 written since reset, or ra1==0.
- rd2_valid  output  1  register at ra2 written since reset, or ra2==0.
- wr_count  output  CNT_W  number of committed writes since reset.
- last_wa  output  ADDR_W  address of the most recent committed write.

Behaviour:
- Storage:
  - Array regs[0..31], plus valid bits vld[1..31].
  - Register 0 has no storage: it always reads 0 and always reports valid=1.
- Reset (reset==0 at a rising clk edge):
  - All regs cleared to 0; all vld cleared.
  - wr_count=0, last_wa=0.
  - Reset overrides any simultaneous write.
  - Reset asserted mid-stream: the write in the same cycle is discarded; the clear takes effect that edge.
- Write commit: at a rising edge with reset==1, we==1 and wa!=0:
  - regs[wa]<=wd; vld[wa]<=1.
  - wr_count<=wr_count+1, wrapping modulo 2**CNT_W (0xFFFF -> 0x0000).
  - last_wa<=wa.
- Writes that do not commit:
  - we==1 with wa==0: no state change at all; wr_count does not increment, last_wa unchanged.
  - we==0: no state change.
  - wa, wd and we must be stable before the rising edge; they are sampled only at the edge.
- Reads:
  - Combinational: rd1=regs[ra1], rd2=regs[ra2]; 0 when the address is 0.
  - Latency 0 from an address change; reflects state after the last edge.
  - rdN_valid follows the same rule using vld.
- Same-cycle read/write to the same address (without the optional feature):
  - Read returns the OLD value; the new value is visible the cycle after the edge.
  - Pipeline control handles the WB->ID hazard.
- ra1==ra2: both ports return identical data.
- Outputs are X-free after the first reset edge.
- wa comes from the mux, which may glitch combinationally; only its value at the edge matters.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass.
  - If we==1, wa!=0 and raN==wa, then rdN=wd and rdN_valid=1 combinationally in the same cycle.
  - Address 0 is never bypassed; it stays 0.
  - Storage and counter behaviour are unchanged.
- Undefined: no bypass; same-cycle reads return the old value as described above.

Test Plan:
- Reset, then read all 32 addresses -> rd1=rd2=0 at every address; rdN_valid=0 except address 0 (valid=1); wr_count=0.
- Write wa=5'b01001 (d1 selected by the mux), wd=32'hDEADBEEF, one edge -> next cycle ra1=9 gives rd1=32'hDEADBEEF, rd1_valid=1; wr_count=1; last_wa=9.
- Write wa=0, wd=32'hFFFFFFFF -> rd at address 0 stays 0; wr_count unchanged; last_wa unchanged.
- Same-cycle we=1, wa=3, wd=32'h12345678, ra2=3, with regs[3] previously 32'h00000011 -> rd2=32'h00000011 before the edge without REGFILE_BYPASS_EN, 32'h12345678 with it; after the edge both builds read 32'h12345678.
- Write to address 31 in the same cycle that reset=0 -> after the edge regs[31]=0, vld[31]=0, wr_count=0.
- 65537 committed writes to wa=1 with incrementing wd -> wr_count wraps to 1; rd at address 1 equals the final wd.

Source files
------------

// File: rtl/mips_regfile_wr_if.sv
// Register-file port bundle: one synchronous write port (WB stage), two
// combinational read ports (ID stage) and the debug/status outputs.
//
// Write port protocol: there is no valid/ready handshake. we, wa and wd are
// sampled only at the rising clk edge; a write commits when we==1 and wa!=0
// and is always accepted (the register file never back-pressures). Read
// ports are pure combinational lookups with no handshake.
interface mips_regfile_wr_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rd1_valid;
    logic              rd2_valid;
    logic [CNT_W-1:0]  wr_count;
    logic [ADDR_W-1:0] last_wa;

    // Pipeline side: drives write and read addresses, observes results.
    modport master (
        output we, wa, wd, ra1, ra2,
        input  rd1, rd2, rd1_valid, rd2_valid, wr_count, last_wa
    );

    // Register-file side.
    modport slave (
        input  we, wa, wd, ra1, ra2,
        output rd1, rd2, rd1_valid, rd2_valid, wr_count, last_wa
    );
endinterface

// File: rtl/mips_regfile_wr.sv
// MIPS 32 x 32 register file fed by the RegDst write-register mux.
// Two asynchronous read ports, one synchronous write port, per-register
// "written since reset" tracking and a committed-write counter.
// Register 0 is hard-wired to zero and always reports valid.
//
// Optional build macro REGFILE_BYPASS_EN: when defined, a read port whose
// address matches an in-flight write (we==1, wa!=0) returns wd and
// valid=1 in the same cycle. When undefined, same-cycle reads see the old
// value and the pipeline is responsible for the WB->ID hazard.
module mips_regfile_wr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input logic             clk,
    input logic             reset,
    mips_regfile_wr_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Slot 0 exists only to keep indexing regular; it is never written
    // after reset and the read path forces address 0 to zero anyway.
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  wr_count_d;
    logic [ADDR_W-1:0] last_wa_q;
    logic              commit;

    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;
    logic              rd1_valid_d;
    logic              rd2_valid_d;

    // A write commits only for a non-zero target; wa==0 writes are dropped.
    assign commit     = rf.we && (rf.wa != '0);
    assign wr_count_d = wr_count_q + 1'b1;

    // Storage, valid bits and debug counters; reset wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            vld_q      <= '0;
            wr_count_q <= '0;
            last_wa_q  <= '0;
        end else if (commit) begin
            regs_q[rf.wa] <= rf.wd;
            vld_q[rf.wa]  <= 1'b1;
            wr_count_q    <= wr_count_d;
            last_wa_q     <= rf.wa;
        end
    end

    // Combinational read ports, with optional same-cycle write-through.
    always_comb begin
        rd1_d       = '0;
        rd2_d       = '0;
        rd1_valid_d = 1'b1;
        rd2_valid_d = 1'b1;
        if (rf.ra1 != '0) begin
            rd1_d       = regs_q[rf.ra1];
            rd1_valid_d = vld_q[rf.ra1];
        end
        if (rf.ra2 != '0) begin
            rd2_d       = regs_q[rf.ra2];
            rd2_valid_d = vld_q[rf.ra2];
        end
`ifdef REGFILE_BYPASS_EN
        // commit already excludes wa==0, so address 0 is never bypassed.
        if (commit && (rf.ra1 == rf.wa)) begin
            rd1_d       = rf.wd;
            rd1_valid_d = 1'b1;
        end
        if (commit && (rf.ra2 == rf.wa)) begin
            rd2_d       = rf.wd;
            rd2_valid_d = 1'b1;
        end
`endif
    end

    assign rf.rd1       = rd1_d;
    assign rf.rd2       = rd2_d;
    assign rf.rd1_valid = rd1_valid_d;
    assign rf.rd2_valid = rd2_valid_d;
    assign rf.wr_count  = wr_count_q;
    assign rf.last_wa   = last_wa_q;
endmodule
